tap_tms_driver: RTL and testbench

- JTAG/TAP initiator: generates the TMS stream that moves a TAP controller, such as TAP_route, to a requested stable state.
- Keeps a cycle-accurate shadow model of the target TAP state.
- Checks the model against the target's 4-bit state observation bus.
- Sits on the tester side of the chip. Shares GCLK_Pad with the TAP; its TMS_Pad output feeds the TAP's TMS_Pad input.

---
 rtl/tap_tms_driver.sv | 185 ++++++++++++++++++
 tb/tb_tap_tms_driver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tap_tms_driver.sv
// JTAG TAP initiator: drives TMS to walk a target TAP controller to a
// requested stable state, tracks a shadow copy of the TAP state and flags
// any disagreement with the target's observed state.
module tap_tms_driver #(
    parameter int SYNC_LEN  = 5,
    parameter int MAX_STEPS = 8
) (
    input  logic       GCLK_Pad,
    input  logic       TRST_Pad,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_state,
    input  logic       req_sync,
    output logic       TMS_Pad,
    output logic [3:0] model_state,
    input  logic [3:0] obs_state,
    output logic       done,
    output logic       err_target,
    output logic       mismatch,
    output logic [3:0] step_count
);

    localparam int CNT_W = (SYNC_LEN < 1) ? 1 : $clog2(SYNC_LEN + 1);
    localparam logic [3:0] GUARD = 4'(MAX_STEPS - 1);

    localparam logic [3:0] TLR   = 4'h0, RTI   = 4'h1, SELDR = 4'h2, CAPDR = 4'h3;
    localparam logic [3:0] SHDR  = 4'h4, EX1DR = 4'h5, PAUDR = 4'h6, EX2DR = 4'h7;
    localparam logic [3:0] UPDDR = 4'h8, SELIR = 4'h9, CAPIR = 4'hA, SHIR  = 4'hB;
    localparam logic [3:0] EX1IR = 4'hC, PAUIR = 4'hD, EX2IR = 4'hE, UPDIR = 4'hF;

    typedef enum logic [1:0] {IDLE, SYNC, WALK} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       target_q, target_d;
    logic [3:0]       nxt;
    logic [3:0]       sc_d;
    logic             tms_d, done_d, err_d;

    // IEEE 1149.1 TAP controller transition graph
    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
        logic [3:0] r;
        case (s)
            TLR:   r = tms ? TLR   : RTI;
            RTI:   r = tms ? SELDR : RTI;
            SELDR: r = tms ? SELIR : CAPDR;
            CAPDR: r = tms ? EX1DR : SHDR;
            SHDR:  r = tms ? EX1DR : SHDR;
            EX1DR: r = tms ? UPDDR : PAUDR;
            PAUDR: r = tms ? EX2DR : PAUDR;
            EX2DR: r = tms ? UPDDR : SHDR;
            UPDDR: r = tms ? SELDR : RTI;
            SELIR: r = tms ? TLR   : CAPIR;
            CAPIR: r = tms ? EX1IR : SHIR;
            SHIR:  r = tms ? EX1IR : SHIR;
            EX1IR: r = tms ? UPDIR : PAUIR;
            PAUIR: r = tms ? EX2IR : PAUIR;
            EX2IR: r = tms ? UPDIR : SHIR;
            default: r = tms ? SELDR : RTI;   // UPDIR
        endcase
        return r;
    endfunction

    // TMS value that moves one hop along the shortest path from s towards t
    function automatic logic hop_tms(input logic [3:0] s, input logic [3:0] t);
        logic r;
        case (s)
            TLR:                 r = (t == TLR);
            RTI:                 r = (t != RTI);
            SELDR, EX1DR, EX2DR: r = !((t == SHDR) || (t == PAUDR));
            CAPDR, SHDR:         r = (t != SHDR);
            PAUDR:               r = (t != PAUDR);
            UPDDR:               r = (t != RTI);
            SELIR, EX1IR, EX2IR: r = !((t == SHIR) || (t == PAUIR));
            CAPIR, SHIR:         r = (t != SHIR);
            PAUIR:               r = (t != PAUIR);
            default:             r = (t != RTI);   // UPDIR
        endcase
        return r;
    endfunction

    function automatic logic is_stable(input logic [3:0] s);
        return (s == TLR) || (s == RTI) || (s == SHDR) ||
               (s == PAUDR) || (s == SHIR) || (s == PAUIR);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'h1;
    endfunction

    assign nxt = tap_next(model_state, TMS_Pad);

    // FSM state register
    always_ff @(posedge GCLK_Pad or posedge TRST_Pad) begin
        if (TRST_Pad) fsm_q <= IDLE;
        else          fsm_q <= fsm_d;
    end

    // FSM next-state decode
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_sync)                fsm_d = SYNC;
                    else if (is_stable(req_state)) fsm_d = WALK;
                end
            end
            SYNC: begin
                if (cnt_q <= CNT_W'(1)) fsm_d = WALK;
            end
            WALK: begin
                if ((nxt == target_q) || (step_count >= GUARD)) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // FSM outputs and next values of the registered datapath
    always_comb begin
        req_ready = 1'b0;
        tms_d     = TMS_Pad;
        done_d    = 1'b0;
        err_d     = 1'b0;
        sc_d      = step_count;
        cnt_d     = cnt_q;
        target_d  = target_q;
        case (fsm_q)
            IDLE: begin
                req_ready = 1'b1;
                tms_d     = (nxt == TLR);   // park: hold the stable state reached
                if (req_valid) begin
                    if (req_sync) begin
                        cnt_d = CNT_W'(SYNC_LEN);
                        sc_d  = 4'h0;
                    end else if (is_stable(req_state)) begin
                        target_d = req_state;
                        sc_d     = 4'h0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SYNC: begin
                tms_d = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) target_d = TLR;
            end
            WALK: begin
                tms_d = hop_tms(nxt, target_q);
                sc_d  = sat_inc(step_count);
                if (nxt == target_q)          done_d = 1'b1;
                else if (step_count >= GUARD) err_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // TMS, shadow model, status pulses and sticky mismatch
    always_ff @(posedge GCLK_Pad or posedge TRST_Pad) begin
        if (TRST_Pad) begin
            TMS_Pad     <= 1'b1;
            model_state <= TLR;
            done        <= 1'b0;
            err_target  <= 1'b0;
            mismatch    <= 1'b0;
            step_count  <= 4'h0;
            cnt_q       <= '0;
        end else begin
            TMS_Pad     <= tms_d;
            model_state <= nxt;
            done        <= done_d;
            err_target  <= err_d;
            mismatch    <= mismatch | (obs_state != model_state);
            step_count  <= sc_d;
            cnt_q       <= cnt_d;
        end
    end

    // Walk target; only meaningful while walking, so it carries no reset
    always_ff @(posedge GCLK_Pad) begin
        target_q <= target_d;
    end

endmodule

// File: tb/tb_tap_tms_driver.sv
// Bench for tap_tms_driver: an independent TAP model drives obs_state, directed
// requests push expected completions into a queue, and a monitor pops and
// compares them whenever done or err_target pulses.
module tb_tap_tms_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_sync;
    logic [3:0] req_state;
    logic       req_ready, TMS_Pad, done, err_target, mismatch;
    logic [3:0] model_state, obs_state, step_count;
    logic [3:0] tap_ref;
    logic       force_bad;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit         is_err;
        logic [3:0] model;
        logic [3:0] sc;
    } exp_t;
    exp_t exp_q[$];

    tap_tms_driver #(.SYNC_LEN(5), .MAX_STEPS(8)) dut (
        .GCLK_Pad   (clk),
        .TRST_Pad   (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_state  (req_state),
        .req_sync   (req_sync),
        .TMS_Pad    (TMS_Pad),
        .model_state(model_state),
        .obs_state  (obs_state),
        .done       (done),
        .err_target (err_target),
        .mismatch   (mismatch),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    // Reference target TAP controller
    function automatic logic [3:0] ref_next(input logic [3:0] s, input logic t);
        case (s)
            4'h0: return t ? 4'h0 : 4'h1;
            4'h1: return t ? 4'h2 : 4'h1;
            4'h2: return t ? 4'h9 : 4'h3;
            4'h3: return t ? 4'h5 : 4'h4;
            4'h4: return t ? 4'h5 : 4'h4;
            4'h5: return t ? 4'h8 : 4'h6;
            4'h6: return t ? 4'h7 : 4'h6;
            4'h7: return t ? 4'h8 : 4'h4;
            4'h8: return t ? 4'h2 : 4'h1;
            4'h9: return t ? 4'h0 : 4'hA;
            4'hA: return t ? 4'hC : 4'hB;
            4'hB: return t ? 4'hC : 4'hB;
            4'hC: return t ? 4'hF : 4'hD;
            4'hD: return t ? 4'hE : 4'hD;
            4'hE: return t ? 4'hF : 4'hB;
            default: return t ? 4'h2 : 4'h1;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) tap_ref <= 4'h0;
        else     tap_ref <= ref_next(tap_ref, TMS_Pad);
    end

    assign obs_state = force_bad ? 4'h1 : tap_ref;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the next queued expectation
    always @(negedge clk) begin
        if (!rst && (done || err_target)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pulse: done=%0b err=%0b with no request pending", done, err_target);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", {14'b0, done, err_target}, e.is_err ? 16'h1 : 16'h2);
                check("end_model",  {12'b0, model_state}, {12'b0, e.model});
                check("end_steps",  {12'b0, step_count}, {12'b0, e.sc});
            end
        end
    end

    // Issue one request; check completion latency and the TMS walk sequence
    task automatic do_req(input string name, input logic [3:0] st, input logic sy,
                          input bit is_err, input logic [3:0] e_model, input logic [3:0] e_sc,
                          input int e_lat, input logic [15:0] e_seq, input int e_len,
                          input bit noise);
        exp_t e;
        int lat;
        int len;
        logic [15:0] seq;
        e.is_err = is_err;
        e.model  = e_model;
        e.sc     = e_sc;
        @(negedge clk);
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_state = st;
        req_sync  = sy;
        @(posedge clk);
        #1;
        if (noise) begin
            req_state = 4'h3;
            req_sync  = 1'b0;
        end else begin
            req_valid = 1'b0;
        end
        lat = -1;
        len = 0;
        seq = '0;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (done || err_target) begin
                lat = k;
                break;
            end
            if (k > 0) begin
                seq = {seq[14:0], TMS_Pad};
                len++;
            end
        end
        req_valid = 1'b0;
        if (lat < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: no done/err within 30 edges", name);
        end else begin
            check({name, "_latency"}, 16'(lat), 16'(e_lat));
            check({name, "_tms_len"}, 16'(len), 16'(e_len));
            check({name, "_tms_seq"}, seq, e_seq);
        end
    endtask

    initial begin
        logic tms_before;
        rst = 1'b1;
        req_valid = 1'b0;
        req_sync = 1'b0;
        req_state = 4'h0;
        force_bad = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tms",      {15'b0, TMS_Pad}, 16'h1);
        check("rst_model",    {12'b0, model_state}, 16'h0);
        check("rst_ready",    {15'b0, req_ready}, 16'h1);
        check("rst_mismatch", {15'b0, mismatch}, 16'h0);
        check("rst_done_err", {14'b0, done, err_target}, 16'h0);
        check("rst_steps",    {12'b0, step_count}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("idle_model", {12'b0, model_state}, 16'h0);
        check("idle_tms",   {15'b0, TMS_Pad}, 16'h1);

        do_req("tlr_to_rti", 4'h1, 1'b0, 1'b0, 4'h1, 4'h2, 2, 16'b0, 1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rti_park_tms",   {15'b0, TMS_Pad}, 16'h0);
        check("rti_park_model", {12'b0, model_state}, 16'h1);

        do_req("rti_to_shdr",  4'h4, 1'b0, 1'b0, 4'h4, 4'h4, 4, 16'b100, 3, 1'b0);
        do_req("shdr_to_shir", 4'hB, 1'b0, 1'b0, 4'hB, 4'h7, 7, 16'b111100, 6, 1'b0);

        tms_before = TMS_Pad;
        do_req("illegal_cap", 4'h3, 1'b0, 1'b1, 4'hB, 4'h7, 0, 16'b0, 0, 1'b0);
        check("illegal_ready", {15'b0, req_ready}, 16'h1);
        check("illegal_tms",   {15'b0, TMS_Pad}, {15'b0, tms_before});

        do_req("shir_to_pauir", 4'hD, 1'b0, 1'b0, 4'hD, 4'h3, 3, 16'b10, 2, 1'b0);
        do_req("sync_from_pauir", 4'h6, 1'b1, 1'b0, 4'h0, 4'h1, 6, 16'b11111, 5, 1'b0);
        do_req("tlr_same", 4'h0, 1'b0, 1'b0, 4'h0, 4'h1, 1, 16'b0, 0, 1'b0);
        do_req("tlr_to_paudr_busy_req", 4'h6, 1'b0, 1'b0, 4'h6, 4'h6, 6, 16'b01010, 5, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("no_mismatch_yet", {15'b0, mismatch}, 16'h0);
        @(negedge clk);
        force_bad = 1'b1;
        @(posedge clk);
        #1;
        force_bad = 1'b0;
        check("mismatch_set", {15'b0, mismatch}, 16'h1);
        repeat (4) @(posedge clk);
        #1;
        check("mismatch_sticky", {15'b0, mismatch}, 16'h1);

        // Start a walk PauDR -> RTI and reset in the middle of it
        @(negedge clk);
        req_valid = 1'b1;
        req_state = 4'h1;
        req_sync  = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("walk_busy", {15'b0, req_ready}, 16'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_tms",      {15'b0, TMS_Pad}, 16'h1);
        check("mid_rst_model",    {12'b0, model_state}, 16'h0);
        check("mid_rst_ready",    {15'b0, req_ready}, 16'h1);
        check("mid_rst_mismatch", {15'b0, mismatch}, 16'h0);
        check("mid_rst_pulses",   {14'b0, done, err_target}, 16'h0);
        check("mid_rst_steps",    {12'b0, step_count}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_model",    {12'b0, model_state}, 16'h0);
        check("post_rst_mismatch", {15'b0, mismatch}, 16'h0);
        check("queue_drained",     16'(exp_q.size()), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
